// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment display blocks: digit-word layout,
// idle pin levels and the active-low hex-to-segment table.
package seg7_pkg;

    localparam int DIGITS  = 4;
    localparam int FIELD_W = 5;   // {enable, nibble} per digit
    localparam int NIB_OFS = 0;   // nibble bit offset inside a field
    localparam int EN_OFS  = 4;   // enable bit offset inside a field

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low segments {g,f,e,d,c,b,a} for hex digits 0..F (dp excluded).
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure table lookup; no dp handling so other display blocks can reuse it.
    always_comb begin
        seg = HEX_SEG[hex];
    end

endmodule

// File: rtl/seg7_scan_blink.sv
// Four-digit multiplexed seven-segment driver with frame-coherent input
// snapshot, per-slot anti-ghosting blanking, per-digit blink and dp.
// All pins are registered and active-low.
module seg7_scan_blink
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK      = 4,
    parameter int BLINK_HALF = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] in,
    input  logic [3:0]  blink,
    input  logic [3:0]  dp,
    output logic [7:0]  sevenSeg,
    output logic [3:0]  anode
);

    localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   BLANK_END = CNT_W'(BLANK);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0]   cnt;
    logic [1:0]         idx;
    logic [BLINK_W-1:0] blinkCnt;
    logic               phase;
    logic [19:0]        snapIn;
    logic [3:0]         snapBlink;
    logic [3:0]         snapDp;

    logic [FIELD_W-1:0] curField;
    logic [3:0]         curNib;
    logic               curEn;
    logic               show;
    logic [6:0]         curSeg;
    logic [3:0]         nextAnode;
    logic [7:0]         nextSeg;

    // Slot counter and digit index: idx advances each time cnt wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Free-running blink half-period timer; phase=1 is the visible half.
    always_ff @(posedge clk) begin
        if (rst) begin
            blinkCnt <= '0;
            phase    <= 1'b1;
        end else if (blinkCnt == BLINK_MAX) begin
            blinkCnt <= '0;
            phase    <= ~phase;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end

    // Capture inputs once per frame (first cycle of slot 0) so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapIn    <= '0;
            snapBlink <= '0;
            snapDp    <= '0;
        end else if (cnt == '0 && idx == 2'd0) begin
            snapIn    <= in;
            snapBlink <= blink;
            snapDp    <= dp;
        end
    end

    hex_to_seg7 uDecode (
        .hex (curNib),
        .seg (curSeg)
    );

    // Select the current slot's field and decide whether it is lit this cycle.
    always_comb begin
        curField  = snapIn[int'(idx) * FIELD_W +: FIELD_W];
        curNib    = curField[NIB_OFS +: 4];
        curEn     = curField[EN_OFS];
        show      = (cnt >= BLANK_END) && curEn && (!snapBlink[idx] || phase);
        nextAnode = AN_OFF;
        nextSeg   = SEG_BLANK;
        if (show) begin
            nextAnode = ~(4'b0001 << idx);
            nextSeg   = {~snapDp[idx], curSeg};
        end
    end

    // Output registers; only one anode can ever be low since idx selects one bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode    <= AN_OFF;
            sevenSeg <= SEG_BLANK;
        end else begin
            anode    <= nextAnode;
            sevenSeg <= nextSeg;
        end
    end

endmodule

// File: tb/tb_seg7_scan_blink.sv
// Bench for seg7_scan_blink with small scan/blink periods. The reference
// model derives every pin value from elapsed cycles since reset.
module tb_seg7_scan_blink;

    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int BH    = 64;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] in;
    logic [3:0]  blink;
    logic [3:0]  dp;
    logic [7:0]  sevenSeg;
    logic [3:0]  anode;

    int assertCount = 0;
    int failCount   = 0;
    int nCur        = 0;

    logic [19:0] mIn;
    logic [3:0]  mBlink;
    logic [3:0]  mDp;
    logic [11:0] expQ[$];

    // Active-low segment bytes with dp off, digits 0..F.
    logic [7:0] refByte [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg7_scan_blink #(
        .SCAN_DIV   (SD),
        .BLANK      (BL),
        .BLINK_HALF (BH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .blink    (blink),
        .dp       (dp),
        .sevenSeg (sevenSeg),
        .anode    (anode)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {anode, sevenSeg} for the internal state n cycles after reset.
    function automatic logic [11:0] modelOut(int n);
        int         slot;
        int         pos;
        bit         visible;
        logic [3:0] an;
        logic [7:0] sb;
        slot    = (n / SD) % 4;
        pos     = n % SD;
        visible = ((n / BH) % 2) == 0;
        an = 4'hF;
        sb = 8'hFF;
        if (pos >= BL && mIn[slot*5+4] && (!mBlink[slot] || visible)) begin
            an[slot] = 1'b0;
            sb       = refByte[mIn[slot*5 +: 4]];
            sb[7]    = ~mDp[slot];
        end
        return {an, sb};
    endfunction

    task automatic check();
        logic [11:0] e;
        e = expQ.pop_front();
        assertCount++;
        assert (anode === e[11:8])
        else begin
            failCount++;
            $error("FAIL anode n=%0d got %h want %h", nCur, anode, e[11:8]);
        end
        assertCount++;
        assert (sevenSeg === e[7:0])
        else begin
            failCount++;
            $error("FAIL sevenSeg n=%0d got %h want %h", nCur, sevenSeg, e[7:0]);
        end
        assertCount++;
        assert ($countones(~anode) <= 1)
        else begin
            failCount++;
            $error("FAIL onehot n=%0d anode got %b want at most one low", nCur, anode);
        end
    endtask

    // Advance one clock, update the model with what the DUT sampled, then check.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            expQ.push_back({4'hF, 8'hFF});
            nCur   = 0;
            mIn    = '0;
            mBlink = '0;
            mDp    = '0;
        end else begin
            if (nCur % FRAME == 0) begin
                mIn    = in;
                mBlink = blink;
                mDp    = dp;
            end
            expQ.push_back(modelOut(nCur));
            nCur++;
        end
        #1;
        check();
    endtask

    task automatic runCycles(int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic runTo(int framePos);
        for (int i = 0; i < FRAME && (nCur % FRAME) != framePos; i++) tick();
    endtask

    initial begin
        rst   = 1'b1;
        in    = '0;
        blink = '0;
        dp    = '0;
        runCycles(3);
        rst = 1'b0;
        runCycles(FRAME);

        // 3,2,1,0 all enabled
        in = {1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 4'h1, 1'b1, 4'h0};
        runCycles(2 * FRAME);

        // digit 2 disabled
        in[14] = 1'b0;
        runCycles(FRAME);

        // change inputs in the middle of slot 2
        runTo(2 * SD + 2);
        in = $urandom_range(0, 20'hFFFFF);
        runCycles(FRAME + 14);

        // blink + dp on digit 0 showing A
        in    = {1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 4'h1, 1'b1, 4'hA};
        blink = 4'b0001;
        dp    = 4'b0001;
        runCycles(5 * FRAME);

        // reset pulse in the middle of slot 1
        runTo(SD + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        runCycles(FRAME + 8);

        // random traffic with occasional mid-frame changes
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    in    = $urandom_range(0, 20'hFFFFF);
                    blink = 4'($urandom_range(0, 15));
                    dp    = 4'($urandom_range(0, 15));
                end
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
